// File: rtl/ps2_kbd_rx_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver feeding the KBUF register.
package ps2_kbd_rx_pkg;

    localparam int SFR_OP_LEN = 4;
    localparam logic [SFR_OP_LEN-1:0] OP_KBUF_WR_BYTE = 4'h5;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

    typedef enum logic [1:0] {
        PS2_IDLE   = 2'd0,
        PS2_DATA   = 2'd1,
        PS2_PARITY = 2'd2,
        PS2_STOP   = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus stability filter for one PS/2 line; emits a one-cycle
// pulse in the first cycle the filtered level reads low.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic [1:0]    sync;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync       <= 2'b11;
            stable_cnt <= '0;
            o_level    <= 1'b1;
            o_fall     <= 1'b0;
        end else begin
            sync   <= {sync[0], i_line};
            o_fall <= 1'b0;
            // any sample matching the current level restarts the run
            if (sync[1] == o_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
                stable_cnt <= '0;
                o_level    <= sync[1];
                o_fall     <= o_level;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host deframer: filters the lines, checks odd parity and stop bit,
// and writes accepted scan codes to KBUF with a matching interrupt pulse.
//
//   state      | meaning
//   PS2_IDLE   | waiting for a falling edge with data low (start bit)
//   PS2_DATA   | shifting in 8 data bits, LSB first
//   PS2_PARITY | sampling the odd-parity bit
//   PS2_STOP   | sampling the stop bit, then deliver or flag an error
module ps2_kbd_rx
    import ps2_kbd_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FILTER_BREAK   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ps2_clk,
    input  logic                  i_ps2_data,
    output logic [7:0]            o_byte,
    output logic [SFR_OP_LEN-1:0] o_op,
    output logic                  o_irq,
    output logic                  o_err,
    output logic                  o_busy
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic clk_lvl_unused;
    logic clk_fall;
    logic data_lvl;
    logic data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_line  (i_ps2_clk),
        .o_level (clk_lvl_unused),
        .o_fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_line  (i_ps2_data),
        .o_level (data_lvl),
        .o_fall  (data_fall_unused)
    );

    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_acc;
    logic          par_ok;
    logic          break_pending;
    logic [TW-1:0] tmo_cnt;

    assign o_busy = (state != PS2_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= PS2_IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            par_acc       <= 1'b0;
            par_ok        <= 1'b0;
            break_pending <= 1'b0;
            tmo_cnt       <= '0;
            o_byte        <= '0;
            o_op          <= '0;
            o_irq         <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_op  <= '0;
            o_irq <= 1'b0;
            o_err <= 1'b0;

            if (state == PS2_IDLE || clk_fall) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            // an edge landing on the threshold cycle wins over the timeout
            if (clk_fall) begin
                case (state)
                    PS2_IDLE: begin
                        if (!data_lvl) begin
                            state   <= PS2_DATA;
                            bit_cnt <= '0;
                            par_acc <= 1'b0;
                        end
                    end
                    PS2_DATA: begin
                        shift   <= {data_lvl, shift[7:1]};
                        par_acc <= par_acc ^ data_lvl;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PS2_PARITY;
                        end
                    end
                    PS2_PARITY: begin
                        par_ok <= par_acc ^ data_lvl;
                        state  <= PS2_STOP;
                    end
                    PS2_STOP: begin
                        state <= PS2_IDLE;
                        if (par_ok && data_lvl) begin
                            if (FILTER_BREAK != 0 && break_pending) begin
                                break_pending <= 1'b0;
                            end else if (FILTER_BREAK != 0 && shift == PS2_BREAK_CODE) begin
                                break_pending <= 1'b1;
                            end else begin
                                o_byte <= shift;
                                o_op   <= OP_KBUF_WR_BYTE;
                                o_irq  <= 1'b1;
                            end
                        end else begin
                            o_err         <= 1'b1;
                            break_pending <= 1'b0;
                        end
                    end
                    default: state <= PS2_IDLE;
                endcase
            end else if (state != PS2_IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                o_err         <= 1'b1;
                state         <= PS2_IDLE;
                break_pending <= 1'b0;
                shift         <= '0;
                tmo_cnt       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Frame-level bench for ps2_kbd_rx: a break-filtering and a pass-all instance share
// the same PS/2 stimulus and are compared against a scan-code level model.
module tb_ps2_kbd_rx;
    import ps2_kbd_rx_pkg::*;

    localparam int FL   = 8;
    localparam int TMO  = 400;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    logic [7:0]            byte_b, byte_n;
    logic [SFR_OP_LEN-1:0] op_b, op_n;
    logic                  irq_b, irq_n, err_b, err_n, busy_b, busy_n;

    always #5 clk = ~clk;

    ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FILTER_BREAK(1)) dut_brk (
        .i_clk(clk), .i_rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
        .o_byte(byte_b), .o_op(op_b), .o_irq(irq_b), .o_err(err_b), .o_busy(busy_b)
    );

    ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FILTER_BREAK(0)) dut_raw (
        .i_clk(clk), .i_rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
        .o_byte(byte_n), .o_op(op_n), .o_irq(irq_n), .o_err(err_n), .o_busy(busy_n)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // observed write pulses and error pulses
    int         ncyc = 0;
    logic [7:0] q_b[$];
    logic [7:0] q_n[$];
    int         qc_n[$];
    int         errs_b = 0;
    int         errs_n = 0;
    bit         busy_seen = 0;

    always @(negedge clk) begin
        ncyc++;
        if (op_b != 0 || irq_b) begin
            chk("op_irq_brk", {27'd0, irq_b, op_b}, {27'd0, 1'b1, OP_KBUF_WR_BYTE});
            q_b.push_back(byte_b);
        end
        if (op_n != 0 || irq_n) begin
            chk("op_irq_raw", {27'd0, irq_n, op_n}, {27'd0, 1'b1, OP_KBUF_WR_BYTE});
            q_n.push_back(byte_n);
            qc_n.push_back(ncyc);
        end
        if (err_b) errs_b++;
        if (err_n) errs_n++;
        if (busy_b || busy_n) busy_seen = 1;
    end

    // reference model state
    bit         mbp = 0;
    logic [7:0] mlast_b = 8'h00;
    logic [7:0] mlast_n = 8'h00;
    int         stop_cyc = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        q_b.delete();
        q_n.delete();
        qc_n.delete();
        errs_b = 0;
        errs_n = 0;
        busy_seen = 0;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == glitch_at) begin
                tick(5);
                ps2_data = ~ps2_data;
                tick(3);
                ps2_data = ~ps2_data;
                tick(HALF - 8);
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = ncyc;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic check_outcome(input int eop_b, input int eop_n, input int eerr,
                                 input logic [7:0] d);
        int lat;
        chk("ops_brk", q_b.size(), eop_b);
        chk("ops_raw", q_n.size(), eop_n);
        if (eop_b == 1 && q_b.size() > 0) chk("byte_brk", q_b[0], d);
        if (eop_n == 1 && q_n.size() > 0) begin
            chk("byte_raw", q_n[0], d);
            lat = qc_n[0] - stop_cyc;
            chk("latency_raw", (lat >= FL + 2 && lat <= FL + 5), 1);
        end
        chk("obyte_brk", byte_b, mlast_b);
        chk("obyte_raw", byte_n, mlast_n);
        chk("err_brk", errs_b, eerr);
        chk("err_raw", errs_n, eerr);
        chk("busy_end", {busy_b, busy_n}, 0);
        clear_obs();
    endtask

    task automatic frame(input logic [7:0] d, input logic par, input logic stop, input int glitch_at);
        bit valid;
        int eop_b, eop_n, eerr;
        valid = ((^{d, par}) == 1'b1) && stop;
        eop_b = 0; eop_n = 0; eerr = 0;
        if (!valid) begin
            eerr = 1;
            mbp = 0;
        end else begin
            eop_n = 1;
            mlast_n = d;
            if (mbp) mbp = 0;
            else if (d == 8'hF0) mbp = 1;
            else begin
                eop_b = 1;
                mlast_b = d;
            end
        end
        send_bits({stop, par, d, 1'b0}, 11, glitch_at);
        tick(HALF + FL + 10);
        check_outcome(eop_b, eop_n, eerr, d);
    endtask

    task automatic good(input logic [7:0] d, input int glitch_at);
        frame(d, ~(^d), 1'b1, glitch_at);
    endtask

    initial begin
        tick(3);
        @(negedge clk);
        chk("rst_byte", {byte_b, byte_n}, 0);
        chk("rst_op", {op_b, op_n}, 0);
        chk("rst_flags", {irq_b, irq_n, err_b, err_n, busy_b, busy_n}, 0);
        rst = 1'b0;
        tick(5);
        clear_obs();

        good(8'h1C, -1);
        frame(8'hF0, 1'b1, 1'b1, -1);
        frame(8'h1C, 1'b0, 1'b1, -1);
        frame(8'h1C, 1'b1, 1'b1, -1);
        frame(8'h29, 1'b0, 1'b1, -1);
        good(8'hE0, -1);
        frame(8'h45, ~(^8'h45), 1'b0, -1);

        // break pending, then a timed-out partial frame, then recovery
        good(8'hF0, -1);
        send_bits(11'b000_0000_1010, 5, -1);
        tick(FL + 6);
        chk("busy_mid", {busy_b, busy_n}, 2'b11);
        tick(TMO + 10);
        mbp = 0;
        check_outcome(0, 0, 1, 8'h00);
        frame(8'h5A, 1'b1, 1'b1, -1);

        // short clock glitch and a spurious edge with data high, both while idle
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(30);
        ps2_data = 1'b1;
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
        tick(HALF + FL + 10);
        chk("idle_busy", busy_seen, 0);
        check_outcome(0, 0, 0, 8'h00);
        good(8'h33, 3);

        // reset after the 5th data bit
        send_bits({1'b1, 1'b0, 8'h16, 1'b0}, 6, -1);
        tick(HALF);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        chk("rst_mid_out", {byte_b, byte_n, op_b, op_n, irq_b, irq_n, err_b, err_n, busy_b, busy_n}, 0);
        rst = 1'b0;
        mbp = 0;
        mlast_b = 8'h00;
        mlast_n = 8'h00;
        tick(HALF);
        chk("rst_mid_err", errs_b + errs_n, 0);
        clear_obs();
        frame(8'h16, 1'b0, 1'b1, -1);

        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            logic       par;
            logic       stop;
            int         g;
            d    = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
            par  = ~(^d);
            if ($urandom_range(0, 5) == 0) par = ~par;
            stop = ($urandom_range(0, 9) != 0);
            g    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : -1;
            frame(d, par, stop, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the KBUF special function register. It synchronises and glitch-filters the external PS/2 clock and data lines, deframes 11-bit device-to-host frames and checks parity and stop bit. Each accepted scan-code byte is delivered to KBUF as a one-cycle OP_KBUF_WR_BYTE write, with a matching keyboard interrupt pulse. Break sequences (F0 xx) are optionally suppressed, so software sees make codes only.

Parameters:
FILTER_LEN, 8, cycles a synchronised PS/2 line must hold a new level before the filtered level changes (minimum 2)
TIMEOUT_CYCLES, 100000, maximum cycles between falling edges inside a frame before the frame is aborted (2 ms at 50 MHz)
FILTER_BREAK, 1, 1 = drop 0xF0 and the byte that follows it; 0 = pass every byte

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset
i_ps2_clk  input  1  raw PS/2 clock pin, asynchronous
i_ps2_data  input  1  raw PS/2 data pin, asynchronous
o_byte  output  8  last accepted scan code; held stable between writes; connects to KBUF i_byte
o_op  output  SFR_OP_LEN  equals OP_KBUF_WR_BYTE for one cycle per accepted byte, otherwise 0; connects to KBUF i_op
o_irq  output  1  one-cycle pulse, coincident with o_op
o_err  output  1  one-cycle pulse on a parity error, stop-bit error or timeout
o_busy  output  1  high while a frame is in progress (state != IDLE)

Interface decided: one clock, i_clk; reset i_rst is synchronous and active-high. Every register is cleared on the i_clk edge at which i_rst = 1.

Behaviour:
- Reset values: o_byte=0x00, o_op=0, o_irq=0, o_err=0, o_busy=0, state=IDLE, break_pending=0, bit counter=0, timeout counter=0, filtered lines=1.
- Input conditioning, per line:
  - 2-flop synchroniser, then a stability counter.
  - The filtered level takes the synchronised value only after FILTER_LEN consecutive equal samples that differ from the current filtered level.
  - fall = one-cycle pulse when the filtered clock goes 1->0.
- All bit sampling uses the filtered data line in the cycle in which fall is high.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit) -> DATA, bit counter=0, parity accumulator=0. On fall with data=1 -> stay in IDLE (spurious edge, no error).
  - DATA: on fall, shift the data bit in LSB first and XOR it into the parity accumulator. After the 8th bit (counter=7) -> PARITY.
  - PARITY: on fall, parity_ok = acc XOR data == 1 (odd parity) -> STOP.
  - STOP: on fall -> IDLE. Frame valid iff parity_ok and data=1; otherwise pulse o_err for 1 cycle.
- Output latency: o_byte, o_op and o_irq update on the clock edge immediately after the cycle in which fall is sampled in STOP (1 cycle).
- Break filtering (FILTER_BREAK=1):
  - A valid 0xF0 sets break_pending and produces no output.
  - The next valid byte clears break_pending and produces no output; o_byte is unchanged.
  - 0xE0 is passed through like any other byte.
  - Any error clears break_pending.
- Timeout:
  - The counter clears on every fall and increments in states other than IDLE.
  - On reaching TIMEOUT_CYCLES-1: pulse o_err, go to IDLE, clear break_pending and discard the partial byte.
  - Counter is held at 0 in IDLE.
- Simultaneous events: a fall in the same cycle as the timeout threshold counts as a valid edge, so the timeout does not fire.
- Reset mid-frame: the frame is discarded, no o_op and no o_err are produced, and the next start bit is accepted normally.
- There is no back-pressure: KBUF accepts a write every cycle. A new byte overwrites o_byte; overrun detection is left to software via o_irq.

Decomposition:
- Defines.v (shared) holds SFR_OP_LEN and OP_KBUF_WR_BYTE (already present). Add PS2_BREAK_CODE = 8'hF0, PS2_EXT_CODE = 8'hE0, and the FSM state encodings PS2_IDLE, PS2_DATA, PS2_PARITY, PS2_STOP.
- Sub-module ps2_line_filter (synchroniser, stability filter, falling-edge pulse; parameter FILTER_LEN), instantiated once per line; the fall output is used only on the clock instance.
- Top FSM, shift register and timeout counter live in ps2_kbd_rx.

Test Plan:
- Valid byte: frame for 0x1C (bits 0,00111000,0,1) at a 12 kHz PS/2 clock -> o_op=OP_KBUF_WR_BYTE and o_irq high for exactly 1 cycle, o_byte=0x1C, o_err=0; a connected KBUF reads 0x1C.
- Break suppression with FILTER_BREAK=1: send 0xF0 (parity 1), then 0x1C -> no o_op pulses and o_byte stays at its prior value. With FILTER_BREAK=0 the same stimulus gives two pulses, with o_byte=0xF0 and then 0x1C.
- Parity error: 0x1C sent with parity bit 1 -> o_err 1-cycle pulse, no o_op. A following valid 0x29 (parity 0) -> o_byte=0x29.
- Timeout and recovery: start bit plus 4 data bits, then the clock held high for TIMEOUT_CYCLES+10 -> one o_err pulse and o_busy falls. A following valid 0x5A (parity 1) is accepted.
- Glitch rejection: a 3-cycle low pulse on i_ps2_clk with FILTER_LEN=8 while idle -> no state change and o_busy stays 0. The same test applies a 3-cycle glitch on data mid-bit.
- Reset mid-frame: assert i_rst after the 5th data bit -> all outputs 0 the next cycle and no o_err. A complete frame for 0x16 afterwards -> o_byte=0x16 with one o_op pulse.
